commit_unit_nw: RTL and testbench

//  Parametrised N-wide in-order commit stage between ROB head and rename/CP0/IF0.

---
 rtl/commit_pkg.sv | 41 ++++
 rtl/commit_select.sv | 66 ++++++
 rtl/commit_unit_nw.sv | 245 ++++++++++++++++++++++++
 tb/tb_commit_unit_nw.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared types for the N-wide commit stage: exception codes, rename-commit payload, FSM states.
package commit_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam int          ARF_W_DEF      = 5;
  localparam int          PRF_W_DEF      = 6;

  // MIPS Cause.ExcCode values; AdEF and Eret are internal markers carried by the ROB
  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_IBE  = 5'h06,
    EXC_DBE  = 5'h07,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_CPU  = 5'h0B,
    EXC_OV   = 5'h0C,
    EXC_TR   = 5'h0D,
    EXC_ADEF = 5'h14,
    EXC_ERET = 5'h1F
  } exc_code_e;

  typedef struct packed {
    logic                 we;
    logic [ARF_W_DEF-1:0] arf;
    logic [PRF_W_DEF-1:0] prf;
    logic [PRF_W_DEF-1:0] stale;
  } commit_rename_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DS  = 2'd1,
    ST_REDIRECT = 2'd2
  } commit_fsm_e;

endpackage

// File: rtl/commit_select.sv
// Combinational prefix scan over the ROB head window: commit count, stores released,
// oldest reachable exception and the mispredicted branch (with or without its delay slot).
module commit_select
  import commit_pkg::*;
#(
  parameter int COMMIT_W    = 4,
  parameter int STORE_PORTS = 1,
  parameter int CNT_W       = $clog2(COMMIT_W + 1),
  parameter int SF_W        = $clog2(STORE_PORTS + 1),
  parameter int IDX_W       = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic                wait_ds,
  input  logic [COMMIT_W-1:0] rob_valid,
  input  logic [COMMIT_W-1:0] rob_done,
  input  logic [COMMIT_W-1:0] rob_exc,
  input  logic [COMMIT_W-1:0] rob_is_store,
  input  logic [COMMIT_W-1:0] rob_mispred,
  output logic [CNT_W-1:0]    cnt,
  output logic [SF_W-1:0]     stores,
  output logic                exc_hit,
  output logic [IDX_W-1:0]    exc_idx,
  output logic                mis_hit,
  output logic [IDX_W-1:0]    mis_idx,
  output logic                ds_pair
);

  logic stop;

  always_comb begin
    cnt     = '0;
    stores  = '0;
    exc_hit = 1'b0;
    exc_idx = '0;
    mis_hit = 1'b0;
    mis_idx = '0;
    ds_pair = 1'b0;
    stop    = 1'b0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (!stop) begin
        if (wait_ds && i > 0) begin
          stop = 1'b1;
        end else if (!(rob_valid[i] && rob_done[i])) begin
          stop = 1'b1;
        end else if (rob_exc[i]) begin
          exc_hit = 1'b1;
          exc_idx = IDX_W'(i);
          stop    = 1'b1;
        end else if (rob_is_store[i] && stores == SF_W'(STORE_PORTS)) begin
          stop = 1'b1;
        end else begin
          cnt    = cnt + CNT_W'(1);
          stores = stores + SF_W'(rob_is_store[i]);
          // the slot right after a mispredicted branch is its delay slot: group ends here
          if (mis_hit) begin
            ds_pair = 1'b1;
            stop    = 1'b1;
          end else if (rob_mispred[i] && !wait_ds) begin
            mis_hit = 1'b1;
            mis_idx = IDX_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/commit_unit_nw.sv
// N-wide in-order commit stage: FSM, interrupt latch and registered commit/exception/redirect outputs.
// Optional COMMIT_PERF_CNT_EN adds perf_commit / perf_mispred counters.
module commit_unit_nw
  import commit_pkg::*;
#(
  parameter int          COMMIT_W    = 4,
  parameter int          STORE_PORTS = 1,
  parameter int          ARF_W       = 5,
  parameter int          PRF_W       = 6,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [5:0]                             ext_int,
  input  logic                                   counter_int,
  input  logic                                   status_ie,
  input  logic                                   status_exl,
  input  logic [7:0]                             status_im,
  input  logic [1:0]                             cause_ip_sw,
  input  logic [31:0]                            cp0_epc,
  input  logic [COMMIT_W-1:0]                    rob_valid,
  input  logic [COMMIT_W-1:0]                    rob_done,
  input  logic [COMMIT_W*32-1:0]                 rob_pc,
  input  logic [COMMIT_W-1:0]                    rob_exc,
  input  logic [COMMIT_W*5-1:0]                  rob_exc_code,
  input  logic [COMMIT_W*32-1:0]                 rob_badvaddr,
  input  logic [COMMIT_W-1:0]                    rob_is_ds,
  input  logic [COMMIT_W-1:0]                    rob_is_store,
  input  logic [COMMIT_W-1:0]                    rob_mispred,
  input  logic [COMMIT_W*32-1:0]                 rob_br_target,
  input  logic [COMMIT_W*(1+ARF_W+2*PRF_W)-1:0]  rob_rename,
  output logic [$clog2(COMMIT_W+1)-1:0]          commit_cnt,
  output logic [$clog2(STORE_PORTS+1)-1:0]       store_fire,
  output logic [COMMIT_W-1:0]                    commit_valid,
  output logic [COMMIT_W*(1+ARF_W+2*PRF_W)-1:0]  commit_rename,
  output logic                                   flush,
  output logic                                   redirect_valid,
  output logic [31:0]                            redirect_pc,
  output logic                                   exc_valid,
  output logic [4:0]                             exc_code,
  output logic [31:0]                            exc_pc,
  output logic [31:0]                            exc_badvaddr,
  output logic                                   exc_is_ds
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [63:0]                            perf_commit,
  output logic [63:0]                            perf_mispred
`endif
);

  localparam int CNT_W = $clog2(COMMIT_W + 1);
  localparam int SF_W  = $clog2(STORE_PORTS + 1);
  localparam int IDX_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;
  localparam int RN_W  = 1 + ARF_W + 2 * PRF_W;

  commit_fsm_e          state, state_nx;
  logic [31:0]          tgt_q, tgt_nx;
  logic [4:0]           ext_int_q;
  logic                 int_pending;
  logic [7:0]           int_gen;
  logic                 int_take;
  logic                 unused_ext_int5;

  logic [CNT_W-1:0]     sel_cnt;
  logic [SF_W-1:0]      sel_sf;
  logic                 exc_hit, mis_hit, ds_pair;
  logic [IDX_W-1:0]     exc_idx, mis_idx;
  logic [COMMIT_W:0]    prev_mis;

  logic [CNT_W-1:0]     cnt_nx;
  logic [SF_W-1:0]      sf_nx;
  logic                 exc_nx, ds_nx;
  logic [4:0]           code_nx;
  logic [31:0]          epc_nx, bad_nx;
  logic [COMMIT_W-1:0]  cv_nx;
  logic [COMMIT_W*RN_W-1:0] rn_nx;

  logic [4:0]           e_code, e_code_o;
  logic [31:0]          e_pc_o, e_bad_o, e_tgt;

  commit_select #(
    .COMMIT_W    (COMMIT_W),
    .STORE_PORTS (STORE_PORTS),
    .CNT_W       (CNT_W),
    .SF_W        (SF_W),
    .IDX_W       (IDX_W)
  ) u_select (
    .wait_ds      (state == ST_WAIT_DS),
    .rob_valid    (rob_valid),
    .rob_done     (rob_done),
    .rob_exc      (rob_exc),
    .rob_is_store (rob_is_store),
    .rob_mispred  (rob_mispred),
    .cnt          (sel_cnt),
    .stores       (sel_sf),
    .exc_hit      (exc_hit),
    .exc_idx      (exc_idx),
    .mis_hit      (mis_hit),
    .mis_idx      (mis_idx),
    .ds_pair      (ds_pair)
  );

  assign unused_ext_int5 = ext_int[5];
  assign int_gen  = {counter_int, ext_int_q, cause_ip_sw} & status_im;
  assign int_take = (state == ST_IDLE) && int_pending && rob_valid[0] && rob_done[0] && !rob_is_ds[0];
  assign prev_mis = {rob_mispred, 1'b0};

  // ERET travels as an exception marker; a misaligned EPC turns it into AdEL on the EPC itself
  always_comb begin
    e_code   = rob_exc_code[exc_idx*5 +: 5];
    e_code_o = e_code;
    e_pc_o   = rob_pc[exc_idx*32 +: 32];
    e_bad_o  = rob_badvaddr[exc_idx*32 +: 32];
    e_tgt    = EXC_VECTOR;
    if (e_code == EXC_ERET) begin
      if (cp0_epc[1:0] == 2'b00) begin
        e_bad_o = '0;
        e_tgt   = cp0_epc;
      end else begin
        e_code_o = EXC_ADEL;
        e_pc_o   = cp0_epc;
        e_bad_o  = cp0_epc;
      end
    end
  end

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt_q;
    cnt_nx   = '0;
    sf_nx    = '0;
    exc_nx   = 1'b0;
    code_nx  = EXC_INT;
    epc_nx   = '0;
    bad_nx   = '0;
    ds_nx    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (int_take) begin
          state_nx = ST_REDIRECT;
          tgt_nx   = EXC_VECTOR;
          exc_nx   = 1'b1;
          epc_nx   = rob_pc[31:0];
        end else begin
          cnt_nx = sel_cnt;
          sf_nx  = sel_sf;
          if (exc_hit) begin
            state_nx = ST_REDIRECT;
            tgt_nx   = e_tgt;
            exc_nx   = 1'b1;
            code_nx  = e_code_o;
            epc_nx   = e_pc_o;
            bad_nx   = e_bad_o;
            ds_nx    = rob_is_ds[exc_idx] | prev_mis[exc_idx];
          end else if (mis_hit) begin
            tgt_nx   = rob_br_target[mis_idx*32 +: 32];
            state_nx = ds_pair ? ST_REDIRECT : ST_WAIT_DS;
          end
        end
      end
      ST_WAIT_DS: begin
        cnt_nx = sel_cnt;
        sf_nx  = sel_sf;
        if (exc_hit) begin
          state_nx = ST_REDIRECT;
          tgt_nx   = e_tgt;
          exc_nx   = 1'b1;
          code_nx  = e_code_o;
          epc_nx   = e_pc_o;
          bad_nx   = e_bad_o;
          ds_nx    = 1'b1;
        end else if (sel_cnt != '0) begin
          state_nx = ST_REDIRECT;
        end
      end
      ST_REDIRECT: state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cv_nx = '0;
    rn_nx = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (CNT_W'(i) < cnt_nx) begin
        cv_nx[i]              = 1'b1;
        rn_nx[i*RN_W +: RN_W] = rob_rename[i*RN_W +: RN_W];
      end
    end
  end

  // reset must silence the combinational handshake immediately, not at the next edge
  assign commit_cnt     = rst ? '0 : cnt_nx;
  assign store_fire     = rst ? '0 : sf_nx;
  assign flush          = (state == ST_REDIRECT);
  assign redirect_valid = (state == ST_REDIRECT);
  assign redirect_pc    = (state == ST_REDIRECT) ? tgt_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      tgt_q         <= '0;
      ext_int_q     <= '0;
      int_pending   <= 1'b0;
      commit_valid  <= '0;
      commit_rename <= '0;
      exc_valid     <= 1'b0;
      exc_code      <= '0;
      exc_pc        <= '0;
      exc_badvaddr  <= '0;
      exc_is_ds     <= 1'b0;
    end else begin
      state         <= state_nx;
      tgt_q         <= tgt_nx;
      ext_int_q     <= ext_int[4:0];
      if (int_take)
        int_pending <= 1'b0;
      else if ((|int_gen) && status_ie && !status_exl)
        int_pending <= 1'b1;
      commit_valid  <= cv_nx;
      commit_rename <= rn_nx;
      exc_valid     <= exc_nx;
      exc_code      <= code_nx;
      exc_pc        <= epc_nx;
      exc_badvaddr  <= bad_nx;
      exc_is_ds     <= ds_nx;
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  logic mis_redir;
  assign mis_redir = (state != ST_REDIRECT) && (state_nx == ST_REDIRECT) && !exc_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_commit  <= '0;
      perf_mispred <= '0;
    end else begin
      perf_commit  <= perf_commit + 64'(cnt_nx);
      perf_mispred <= perf_mispred + 64'(mis_redir);
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit_nw.sv
// Directed bench for commit_unit_nw (W=4, one store port): vector table plus multi-cycle sequences.
module tb_commit_unit_nw;
  import commit_pkg::*;

  localparam int W    = 4;
  localparam int RN_W = $bits(commit_rename_t);

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        ext_int;
  logic              counter_int, status_ie, status_exl;
  logic [7:0]        status_im;
  logic [1:0]        cause_ip_sw;
  logic [31:0]       cp0_epc;
  logic [W-1:0]      rob_valid, rob_done, rob_exc, rob_is_ds, rob_is_store, rob_mispred;
  logic [W*32-1:0]   rob_pc, rob_badvaddr, rob_br_target;
  logic [W*5-1:0]    rob_exc_code;
  logic [W*RN_W-1:0] rob_rename;
  logic [2:0]        commit_cnt;
  logic [0:0]        store_fire;
  logic [W-1:0]      commit_valid;
  logic [W*RN_W-1:0] commit_rename;
  logic              flush, redirect_valid, exc_valid, exc_is_ds;
  logic [31:0]       redirect_pc, exc_pc, exc_badvaddr;
  logic [4:0]        exc_code;
`ifdef COMMIT_PERF_CNT_EN
  logic [63:0]       perf_commit, perf_mispred;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  commit_unit_nw dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .counter_int(counter_int),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .cause_ip_sw(cause_ip_sw), .cp0_epc(cp0_epc),
    .rob_valid(rob_valid), .rob_done(rob_done), .rob_pc(rob_pc), .rob_exc(rob_exc),
    .rob_exc_code(rob_exc_code), .rob_badvaddr(rob_badvaddr), .rob_is_ds(rob_is_ds),
    .rob_is_store(rob_is_store), .rob_mispred(rob_mispred), .rob_br_target(rob_br_target),
    .rob_rename(rob_rename),
    .commit_cnt(commit_cnt), .store_fire(store_fire), .commit_valid(commit_valid),
    .commit_rename(commit_rename), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .exc_is_ds(exc_is_ds)
`ifdef COMMIT_PERF_CNT_EN
    , .perf_commit(perf_commit), .perf_mispred(perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic commit_rename_t ren_val(input int i);
    commit_rename_t r;
    r.we    = 1'b1;
    r.arf   = 5'(i + 1);
    r.prf   = 6'(i + 8);
    r.stale = 6'(i + 16);
    return r;
  endfunction

  function automatic logic [W*RN_W-1:0] exp_ren(input int cnt);
    logic [W*RN_W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++)
      if (i < cnt) v[i*RN_W +: RN_W] = ren_val(i);
    return v;
  endfunction

  task automatic clear_win();
    rob_valid = '0; rob_done = '0; rob_exc = '0; rob_is_ds = '0;
    rob_is_store = '0; rob_mispred = '0; rob_exc_code = '0; rob_badvaddr = '0;
    for (int i = 0; i < W; i++) begin
      rob_pc[i*32 +: 32]        = 32'h8000_0000 + 32'(4 * i);
      rob_br_target[i*32 +: 32] = 32'h8000_1000 + 32'(256 * i);
      rob_rename[i*RN_W +: RN_W] = ren_val(i);
    end
  endtask

  task automatic full_win();
    clear_win();
    rob_valid = 4'b1111;
    rob_done  = 4'b1111;
  endtask

  typedef struct {
    logic [3:0] v, d, s;
    logic [2:0] cnt;
    logic       sf;
    logic [3:0] cv;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{4'b1111, 4'b1111, 4'b0000, 3'd4, 1'b0, 4'b1111};
    vt[1] = '{4'b1111, 4'b1111, 4'b0101, 3'd2, 1'b1, 4'b0011};
    vt[2] = '{4'b1111, 4'b1111, 4'b0001, 3'd4, 1'b1, 4'b1111};
    vt[3] = '{4'b1111, 4'b1011, 4'b0000, 3'd2, 1'b0, 4'b0011};
    vt[4] = '{4'b1111, 4'b1110, 4'b0000, 3'd0, 1'b0, 4'b0000};
    vt[5] = '{4'b0011, 4'b1111, 4'b0000, 3'd2, 1'b0, 4'b0011};
    vt[6] = '{4'b1101, 4'b1111, 4'b0000, 3'd1, 1'b0, 4'b0001};
    vt[7] = '{4'b1111, 4'b1111, 4'b1010, 3'd3, 1'b1, 4'b0111};

    rst = 1'b1;
    ext_int = '0; counter_int = 1'b0; status_ie = 1'b0; status_exl = 1'b0;
    status_im = '0; cause_ip_sw = '0; cp0_epc = '0;
    full_win();
    #3;
    chk("reset commit_cnt", commit_cnt, 0);
    chk("reset commit_valid", commit_valid, 0);
    chk("reset flush", flush, 0);
    chk("reset exc_valid", exc_valid, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    #9 rst = 1'b0;
    clear_win();
    step();

    for (int k = 0; k < 8; k++) begin
      clear_win();
      rob_valid = vt[k].v; rob_done = vt[k].d; rob_is_store = vt[k].s;
      #1;
      chk($sformatf("vec%0d commit_cnt", k), commit_cnt, vt[k].cnt);
      chk($sformatf("vec%0d store_fire", k), store_fire, vt[k].sf);
      step();
      chk($sformatf("vec%0d commit_valid", k), commit_valid, vt[k].cv);
      chk($sformatf("vec%0d commit_rename", k), commit_rename, exp_ren(int'(vt[k].cnt)));
      chk($sformatf("vec%0d flush", k), flush, 0);
    end

    // AdEL in slot 1
    full_win();
    rob_exc = 4'b0010;
    rob_exc_code[5 +: 5] = EXC_ADEL;
    rob_badvaddr[32 +: 32] = 32'h0000_1001;
    #1 chk("adel commit_cnt", commit_cnt, 1);
    step();
    chk("adel exc_valid", exc_valid, 1);
    chk("adel exc_code", exc_code, 5'h04);
    chk("adel exc_pc", exc_pc, 32'h8000_0004);
    chk("adel exc_badvaddr", exc_badvaddr, 32'h0000_1001);
    chk("adel exc_is_ds", exc_is_ds, 0);
    chk("adel redirect_valid", redirect_valid, 1);
    chk("adel redirect_pc", redirect_pc, 32'hBFC0_0380);
    chk("adel commit_valid", commit_valid, 4'b0001);
    chk("adel redirect commit_cnt", commit_cnt, 0);
    clear_win();
    step();
    chk("adel pulse ends", {flush, exc_valid}, 0);

    // mispredict in slot 3, delay slot arrives late
    full_win();
    rob_mispred = 4'b1000;
    #1 chk("mis3 commit_cnt", commit_cnt, 4);
    step();
    chk("mis3 commit_valid", commit_valid, 4'b1111);
    chk("mis3 no flush yet", flush, 0);
    full_win();
    rob_done = 4'b1110;
    #1 chk("wait_ds ds not done", commit_cnt, 0);
    step();
    full_win();
    rob_is_ds = 4'b0001;
    #1 chk("wait_ds commits one", commit_cnt, 1);
    step();
    chk("mis3 flush", flush, 1);
    chk("mis3 redirect_valid", redirect_valid, 1);
    chk("mis3 redirect_pc", redirect_pc, 32'h8000_1300);
    chk("mis3 redirect commit_cnt", commit_cnt, 0);
    chk("mis3 ds commit_valid", commit_valid, 4'b0001);
    chk("mis3 no exception", exc_valid, 0);
    clear_win();
    step();
    chk("mis3 flush ends", flush, 0);

    // mispredict in slot 1 with its delay slot in the same group
    full_win();
    rob_mispred = 4'b0010;
    #1 chk("mis1 commit_cnt", commit_cnt, 3);
    step();
    chk("mis1 redirect_valid", redirect_valid, 1);
    chk("mis1 redirect_pc", redirect_pc, 32'h8000_1100);
    chk("mis1 commit_valid", commit_valid, 4'b0111);
    clear_win();
    step();

    // exception in the delay slot of a same-group mispredict
    full_win();
    rob_mispred = 4'b0001;
    rob_exc = 4'b0010;
    rob_exc_code[5 +: 5] = EXC_RI;
    #1 chk("dsexc commit_cnt", commit_cnt, 1);
    step();
    chk("dsexc exc_code", exc_code, 5'h0A);
    chk("dsexc exc_is_ds", exc_is_ds, 1);
    chk("dsexc redirect_pc", redirect_pc, 32'hBFC0_0380);
    clear_win();
    step();

    // external interrupt on ext_int[2] via IM[4]
    ext_int = 6'b000100; status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
    step(); step(); step();
    clear_win();
    rob_valid = 4'b0001; rob_done = 4'b0001; rob_is_ds = 4'b0001;
    #1 chk("int blocked by ds commit_cnt", commit_cnt, 1);
    step();
    chk("int blocked no exc", exc_valid, 0);
    ext_int = '0; status_ie = 1'b0;
    full_win();
    #1 chk("int commit_cnt", commit_cnt, 0);
    step();
    chk("int exc_valid", exc_valid, 1);
    chk("int exc_code", exc_code, 5'h00);
    chk("int exc_pc", exc_pc, 32'h8000_0000);
    chk("int redirect_pc", redirect_pc, 32'hBFC0_0380);
    chk("int commit_valid", commit_valid, 4'b0000);
    clear_win();
    step();
    full_win();
    #1 chk("int cleared commit_cnt", commit_cnt, 4);
    step();
    chk("int cleared no exc", exc_valid, 0);
    status_im = '0;

    // ERET misaligned then aligned
    clear_win();
    rob_valid = 4'b0001; rob_done = 4'b0001; rob_exc = 4'b0001;
    rob_exc_code[4:0] = EXC_ERET;
    cp0_epc = 32'h8000_0002;
    #1 chk("eret bad commit_cnt", commit_cnt, 0);
    step();
    chk("eret bad exc_code", exc_code, 5'h04);
    chk("eret bad exc_pc", exc_pc, 32'h8000_0002);
    chk("eret bad exc_badvaddr", exc_badvaddr, 32'h8000_0002);
    chk("eret bad redirect_pc", redirect_pc, 32'hBFC0_0380);
    clear_win();
    step();
    rob_valid = 4'b0001; rob_done = 4'b0001; rob_exc = 4'b0001;
    rob_exc_code[4:0] = EXC_ERET;
    cp0_epc = 32'h8000_0100;
    step();
    chk("eret ok exc_code", exc_code, 5'h1F);
    chk("eret ok redirect_pc", redirect_pc, 32'h8000_0100);
    clear_win();
    step();

    // reset while waiting for a delay slot
    full_win();
    rob_mispred = 4'b1000;
    step();
    full_win();
    #2 rst = 1'b1;
    #1;
    chk("rst wait_ds commit_cnt", commit_cnt, 0);
    chk("rst wait_ds commit_valid", commit_valid, 0);
    chk("rst wait_ds flush", flush, 0);
    chk("rst wait_ds store_fire", store_fire, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst back to idle commit_cnt", commit_cnt, 4);
    step();
    chk("rst idle no redirect", redirect_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
